// File: rtl/ble_cmd_sequencer.sv
// ble_cmd_sequencer
//   Queues 16-bit Knight's Tour commands and dispatches them one at a time
//   through the BLE RemoteComm transmitter. Each command must be answered
//   with the ACK byte before the next is sent. A NAK (any other byte) or a
//   timeout halts the queue until abort or reset.
//
//   Build option: define SEQ_RETRY_EN to re-send a faulted command up to
//   MAX_RETRY times before halting. Without it every fault halts at once.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   push, push_cmd  enqueue a command word (dropped and ovf set when full)
//   run             level; dispatch allowed while high
//   abort           flush FIFO, clear err/ovf/retries, return to IDLE
//   full, empty     FIFO status
//   cmd, send_cmd   command word and one-cycle start pulse to RemoteComm
//   cmd_sent        RemoteComm finished shifting the command out
//   resp_rdy, resp  RemoteComm response byte valid / value
//   clr_rx_rdy      one-cycle pulse consuming resp_rdy
//   busy            command in flight (SEND / WAIT_SENT / WAIT_RESP)
//   done            one-cycle pulse when an ACK leaves the queue empty
//   err             sticky fault flag (sequencer halted)
//   ovf             sticky push-dropped flag
//   n_acked         wrapping count of acknowledged commands
module ble_cmd_sequencer #(
    parameter int unsigned      DEPTH     = 8,
    parameter logic [7:0]       ACK       = 8'hA5,
    parameter int unsigned      TO_W      = 26,
    parameter logic [TO_W-1:0]  TIMEOUT   = 26'd50_000_000,
    parameter int unsigned      MAX_RETRY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [15:0] push_cmd,
    input  logic        run,
    input  logic        abort,
    output logic        full,
    output logic        empty,
    output logic [15:0] cmd,
    output logic        send_cmd,
    input  logic        cmd_sent,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        clr_rx_rdy,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        ovf,
    output logic [7:0]  n_acked
);

    localparam int unsigned AW = $clog2(DEPTH);

`ifdef SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam logic [7:0]      MAX_R8  = 8'(MAX_RETRY);
    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - 1'b1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SEND      = 3'd1;
    localparam logic [2:0] S_WAIT_SENT = 3'd2;
    localparam logic [2:0] S_WAIT_RESP = 3'd3;
    localparam logic [2:0] S_HALT      = 3'd4;

    logic [2:0]      state;
    logic [15:0]     mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [TO_W-1:0] timer;
    logic [7:0]      retry_cnt;

    logic do_push;
    logic resp_take;
    logic to_hit;
    logic ack_take;
    logic fault;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign send_cmd = (state == S_SEND);
    assign busy     = (state == S_SEND) || (state == S_WAIT_SENT) ||
                      (state == S_WAIT_RESP);

    assign do_push = push && !full && !abort;

    // resp_rdy stays high for the cycle in which clr_rx_rdy is being seen by
    // RemoteComm; ignore it then so one byte yields exactly one clear pulse.
    assign resp_take = resp_rdy && !clr_rx_rdy;

    // Fault fires on the attempt's TIMEOUT-th cycle after SEND.
    assign to_hit = (timer == TO_LAST);

    always_comb begin
        fault    = 1'b0;
        ack_take = 1'b0;
        case (state)
            S_WAIT_SENT: fault = !cmd_sent && to_hit;
            S_WAIT_RESP: begin
                if (resp_take) begin
                    ack_take = (resp == ACK);
                    fault    = (resp != ACK);
                end else begin
                    fault = to_hit;
                end
            end
            default: begin
                fault    = 1'b0;
                ack_take = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            timer      <= '0;
            retry_cnt  <= '0;
            cmd        <= '0;
            clr_rx_rdy <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            ovf        <= 1'b0;
            n_acked    <= '0;
        end else begin
            done       <= 1'b0;
            // Stale bytes (outside WAIT_RESP) are consumed here too.
            clr_rx_rdy <= resp_take;

            if (abort) begin
                rd_ptr    <= wr_ptr;
                state     <= S_IDLE;
                timer     <= '0;
                retry_cnt <= '0;
                err       <= 1'b0;
                ovf       <= 1'b0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                // Full is judged on the registered pointers, so a pop in the
                // same cycle does not rescue the word.
                if (push && full) begin
                    ovf <= 1'b1;
                end

                case (state)
                    S_IDLE: begin
                        if (run && !empty) begin
                            cmd    <= mem[rd_ptr[AW-1:0]];
                            rd_ptr <= rd_ptr + 1'b1;
                            state  <= S_SEND;
                        end
                    end
                    S_SEND: begin
                        timer <= '0;
                        state <= S_WAIT_SENT;
                    end
                    S_WAIT_SENT, S_WAIT_RESP: begin
                        timer <= timer + 1'b1;
                        if (fault) begin
                            if (RETRY_EN && (retry_cnt < MAX_R8)) begin
                                retry_cnt <= retry_cnt + 1'b1;
                                state     <= S_SEND;
                            end else begin
                                err   <= 1'b1;
                                state <= S_HALT;
                            end
                        end else if ((state == S_WAIT_SENT) && cmd_sent) begin
                            state <= S_WAIT_RESP;
                        end else if (ack_take) begin
                            n_acked   <= n_acked + 1'b1;
                            retry_cnt <= '0;
                            done      <= empty;
                            state     <= S_IDLE;
                        end
                    end
                    S_HALT: begin
                        state <= S_HALT;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ble_cmd_sequencer.sv
// tb_ble_cmd_sequencer
//   Directed bench for ble_cmd_sequencer. Accepted commands are queued as
//   expected dispatches; a monitor pops and compares on every send_cmd.
//   Works with or without SEQ_RETRY_EN defined.
module tb_ble_cmd_sequencer;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned TOUT      = 1000;
    localparam int unsigned MAX_RETRY = 2;
`ifdef SEQ_RETRY_EN
    localparam int unsigned RETRIES = MAX_RETRY;
`else
    localparam int unsigned RETRIES = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        push;
    logic [15:0] push_cmd;
    logic        run;
    logic        abort;
    logic        full;
    logic        empty;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        clr_rx_rdy;
    logic        busy;
    logic        done;
    logic        err;
    logic        ovf;
    logic [7:0]  n_acked;

    ble_cmd_sequencer #(
        .DEPTH    (DEPTH),
        .ACK      (8'hA5),
        .TO_W     (26),
        .TIMEOUT  (26'd1000),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_cmd  (push_cmd),
        .run       (run),
        .abort     (abort),
        .full      (full),
        .empty     (empty),
        .cmd       (cmd),
        .send_cmd  (send_cmd),
        .cmd_sent  (cmd_sent),
        .resp_rdy  (resp_rdy),
        .resp      (resp),
        .clr_rx_rdy(clr_rx_rdy),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ovf       (ovf),
        .n_acked   (n_acked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_send = 0;
    int n_done = 0;
    int n_clr = 0;
    int cyc = 0;
    logic prev_send = 1'b0;
    logic prev_done = 1'b0;
    logic prev_clr = 1'b0;
    logic [15:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer and pulse-width monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (send_cmd) begin
                n_send++;
                chk("send_width", 32'(prev_send), 32'd0);
                chk("send_queue_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) chk("send_order", 32'(cmd), 32'(sb.pop_front()));
            end
            if (done) begin
                n_done++;
                chk("done_width", 32'(prev_done), 32'd0);
            end
            if (clr_rx_rdy) begin
                n_clr++;
                chk("clr_width", 32'(prev_clr), 32'd0);
            end
        end
        prev_send = send_cmd;
        prev_done = done;
        prev_clr  = clr_rx_rdy;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_word(input logic [15:0] w, input bit accept);
        push = 1'b1;
        push_cmd = w;
        if (accept) sb.push_back(w);
        tick();
        push = 1'b0;
    endtask

    task automatic wait_send(input string tag);
        for (int i = 0; i < 60 && !send_cmd; i++) tick();
        chk(tag, 32'(send_cmd), 32'd1);
    endtask

    // Called at the negedge of the SEND cycle; returns at the negedge where
    // clr_rx_rdy is seen.
    task automatic serve(input logic [7:0] b, input string tag);
        tick(2);
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
        tick();
        resp = b;
        resp_rdy = 1'b1;
        for (int i = 0; i < 20 && !clr_rx_rdy; i++) tick();
        chk(tag, 32'(clr_rx_rdy), 32'd1);
        resp_rdy = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acked_exp;
        int base_send;
        int base_done;
        int base_clr;
        int s0;

        rst_n = 1'b0; push = 1'b0; push_cmd = '0; run = 1'b0; abort = 1'b0;
        cmd_sent = 1'b0; resp_rdy = 1'b0; resp = '0;
        acked_exp = 0;
        tick(3);
        chk("reset_flags", 32'({send_cmd, clr_rx_rdy, busy, done, err, ovf, full, empty}), 32'b0000_0001);
        chk("reset_cmd", 32'(cmd), 32'd0);
        chk("reset_n_acked", 32'(n_acked), 32'd0);
        rst_n = 1'b1;
        tick();

        // Two commands, both ACKed, dispatched in push order.
        run = 1'b1;
        push_word(16'h2000, 1'b1);
        chk("t1_empty_falls", 32'(empty), 32'd0);
        chk("t1_no_send_yet", 32'(send_cmd), 32'd0);
        push_word(16'h4001, 1'b1);
        chk("t1_send_latency", 32'(send_cmd), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        serve(8'hA5, "t1_clr1");
        acked_exp++;
        chk("t1_n_acked1", 32'(n_acked), 32'(acked_exp));
        chk("t1_no_done_yet", 32'(done), 32'd0);
        wait_send("t1_send2");
        serve(8'hA5, "t1_clr2");
        acked_exp++;
        chk("t1_n_acked2", 32'(n_acked), 32'(acked_exp));
        chk("t1_done", 32'(done), 32'd1);
        tick();
        chk("t1_done_low", 32'(done), 32'd0);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_send_count", 32'(n_send), 32'd2);
        chk("t1_done_count", 32'(n_done), 32'd1);

`ifdef SEQ_RETRY_EN
        // NAK twice then ACK: three identical dispatches.
        base_send = n_send;
        push_word(16'h3001, 1'b1);
        sb.push_back(16'h3001);
        sb.push_back(16'h3001);
        wait_send("t2r_send1");
        serve(8'h5A, "t2r_clr1");
        wait_send("t2r_send2");
        serve(8'h5A, "t2r_clr2");
        wait_send("t2r_send3");
        serve(8'hA5, "t2r_clr3");
        acked_exp++;
        chk("t2r_n_acked", 32'(n_acked), 32'(acked_exp));
        chk("t2r_err", 32'(err), 32'd0);
        chk("t2r_send_count", 32'(n_send - base_send), 32'd3);
        tick(5);
`else
        // NAK on the first of two queued commands halts the queue.
        run = 1'b0;
        push_word(16'h3001, 1'b1);
        push_word(16'h3002, 1'b1);
        base_send = n_send;
        run = 1'b1;
        wait_send("t2_send1");
        serve(8'h5A, "t2_clr");
        chk("t2_err", 32'(err), 32'd1);
        chk("t2_busy_halt", 32'(busy), 32'd0);
        tick(20);
        chk("t2_no_more_send", 32'(n_send - base_send), 32'd1);
        chk("t2_not_empty", 32'(empty), 32'd0);
        chk("t2_err_sticky", 32'(err), 32'd1);
        push = 1'b1;
        push_cmd = 16'h3003;
        do_abort();
        push = 1'b0;
        sb.delete();
        chk("t2_abort_empty", 32'(empty), 32'd1);
        chk("t2_abort_err", 32'(err), 32'd0);
        chk("t2_abort_busy", 32'(busy), 32'd0);
        chk("t2_n_acked_kept", 32'(n_acked), 32'(acked_exp));
        tick(5);
        chk("t2_idle_no_send", 32'(n_send - base_send), 32'd1);
`endif

        // No response ever arrives: timeout fault.
        base_send = n_send;
        push_word(16'h5005, 1'b1);
        for (int i = 0; i < int'(RETRIES); i++) sb.push_back(16'h5005);
        wait_send("t3_send");
        s0 = cyc;
        tick(2);
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
        for (int i = 0; i < 5000 && !err; i++) tick();
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_latency", 32'(cyc - s0), 32'((TOUT + 1) * (RETRIES + 1)));
        chk("t3_sends", 32'(n_send - base_send), 32'(RETRIES + 1));
        tick(20);
        chk("t3_no_more_send", 32'(n_send - base_send), 32'(RETRIES + 1));
        chk("t3_busy", 32'(busy), 32'd0);
        do_abort();
        sb.delete();
        chk("t3_abort_err", 32'(err), 32'd0);

        // Overfill with run low, then drain.
        run = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) push_word(16'h7000 + 16'(i), 1'b1);
        chk("t4_full", 32'(full), 32'd1);
        chk("t4_no_ovf_yet", 32'(ovf), 32'd0);
        push_word(16'h70FF, 1'b0);
        chk("t4_ovf", 32'(ovf), 32'd1);
        chk("t4_still_full", 32'(full), 32'd1);
        base_send = n_send;
        base_done = n_done;
        run = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            wait_send("t4_send");
            serve(8'hA5, "t4_clr");
            acked_exp++;
        end
        tick(10);
        chk("t4_send_count", 32'(n_send - base_send), 32'(DEPTH));
        chk("t4_sb_drained", 32'(sb.size()), 32'd0);
        chk("t4_empty", 32'(empty), 32'd1);
        chk("t4_n_acked", 32'(n_acked), 32'(acked_exp));
        chk("t4_one_done", 32'(n_done - base_done), 32'd1);
        chk("t4_ovf_sticky", 32'(ovf), 32'd1);
        do_abort();
        chk("t4_abort_ovf", 32'(ovf), 32'd0);

        // Abort in WAIT_RESP, then a late response byte.
        push_word(16'h6006, 1'b1);
        wait_send("t5_send");
        tick(2);
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
        tick();
        chk("t5_busy_wait_resp", 32'(busy), 32'd1);
        do_abort();
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_cmd_kept", 32'(cmd), 32'h6006);
        base_clr = n_clr;
        base_done = n_done;
        base_send = n_send;
        tick(2);
        resp = 8'hA5;
        resp_rdy = 1'b1;
        for (int i = 0; i < 20 && !clr_rx_rdy; i++) tick();
        chk("t5_stale_clr", 32'(clr_rx_rdy), 32'd1);
        resp_rdy = 1'b0;
        tick(5);
        chk("t5_n_acked_same", 32'(n_acked), 32'(acked_exp));
        chk("t5_clr_once", 32'(n_clr - base_clr), 32'd1);
        chk("t5_no_done", 32'(n_done - base_done), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_no_send", 32'(n_send - base_send), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
